// File: rtl/tune_player.sv
// tune_player: plays fixed sound-effect tunes (drop/invalid/win) onto the piezo tone generator.
// Latency: a request accepted in cycle t drives note/enable/busy/tune_id in cycle t+1; all outputs registered.
// Backpressure: none; unaccepted requests are discarded (TUNE_PREEMPT_EN: higher priority aborts current tune).
module tune_player #(
    parameter int TICK_CYCLES = 50_000,
    parameter int GAP_TICKS   = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  req,
    output logic [13:0] note,
    output logic        enable,
    output logic        busy,
    output logic        done,
    output logic [1:0]  tune_id
);
    localparam int             PW         = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_CYCLES - 1);
    localparam logic [7:0]     GAP_LEN    = 8'(GAP_TICKS);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

    state_t        state, state_n;
    logic [PW-1:0] presc, presc_n;
    logic [7:0]    dur, dur_n;
    logic [1:0]    idx, idx_n;
    logic [1:0]    tune, tune_n;
    logic          done_n;
    logic          tick, seg_end, start;
    logic [7:0]    seg_len;
    logic          req_any;
    logic [1:0]    req_sel;
    logic [13:0]   note_n;

    function automatic logic [13:0] rom_freq(input logic [1:0] t, input logic [1:0] i);
        case ({t, i})
            4'b00_00: return 14'd880;
            4'b01_00: return 14'd220;
            4'b01_01: return 14'd165;
            4'b10_00: return 14'd523;
            4'b10_01: return 14'd659;
            4'b10_10: return 14'd784;
            4'b10_11: return 14'd1047;
            default:  return 14'd0;
        endcase
    endfunction

    function automatic logic [7:0] rom_dur(input logic [1:0] t, input logic [1:0] i);
        case ({t, i})
            4'b00_00: return 8'd40;
            4'b01_00: return 8'd100;
            4'b01_01: return 8'd150;
            4'b10_00: return 8'd80;
            4'b10_01: return 8'd80;
            4'b10_10: return 8'd80;
            4'b10_11: return 8'd240;
            default:  return 8'd1;
        endcase
    endfunction

    function automatic logic [1:0] tune_last(input logic [1:0] t);
        case (t)
            2'd1:    return 2'd1;
            2'd2:    return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // Fixed priority: win > invalid > drop; losers in the same cycle are dropped.
    assign req_any = |req;
    assign req_sel = req[2] ? 2'd2 : (req[1] ? 2'd1 : 2'd0);

    // Next-state, counters and next registered output values.
    always_comb begin
        state_n = state;
        tune_n  = tune;
        idx_n   = idx;
        presc_n = presc;
        dur_n   = dur;
        done_n  = 1'b0;
        start   = 1'b0;
        tick    = (presc == PRESC_LAST);
        seg_len = (state == S_PLAY) ? rom_dur(tune, idx) : GAP_LEN;
        seg_end = tick && (dur == seg_len - 8'd1);

        case (state)
            S_IDLE: begin
                start = req_any;
            end
            S_PLAY, S_GAP: begin
                if (tick) begin
                    presc_n = '0;
                    dur_n   = dur + 8'd1;
                end else begin
                    presc_n = presc + PW'(1);
                end
                if (seg_end) begin
                    presc_n = '0;
                    dur_n   = '0;
                    if (state == S_PLAY && GAP_TICKS != 0) begin
                        state_n = S_GAP;
                    end else if (idx == tune_last(tune)) begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                    end else begin
                        state_n = S_PLAY;
                        idx_n   = idx + 2'd1;
                    end
                end
`ifdef TUNE_PREEMPT_EN
                // Strictly higher priority aborts the current tune without a done pulse.
                start = req_any && (req_sel > tune);
`endif
            end
            default: state_n = S_IDLE;
        endcase

        // Tune start clears prescaler and duration so the first note is full length.
        if (start) begin
            state_n = S_PLAY;
            tune_n  = req_sel;
            idx_n   = 2'd0;
            presc_n = '0;
            dur_n   = '0;
            done_n  = 1'b0;
        end

        note_n = (state_n == S_PLAY) ? rom_freq(tune_n, idx_n) : 14'd0;
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            presc   <= '0;
            dur     <= '0;
            idx     <= '0;
            tune    <= '0;
            note    <= '0;
            enable  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            tune_id <= 2'd3;
        end else begin
            state   <= state_n;
            presc   <= presc_n;
            dur     <= dur_n;
            idx     <= idx_n;
            tune    <= tune_n;
            note    <= note_n;
            enable  <= (state_n == S_PLAY);
            busy    <= (state_n != S_IDLE);
            done    <= done_n;
            tune_id <= (state_n == S_IDLE) ? 2'd3 : tune_n;
        end
    end
endmodule

// File: tb/tb_tune_player.sv
// tb_tune_player: directed vectors plus hand sequences for tune_player with TICK_CYCLES=4, GAP_TICKS=2.
// Outputs are sampled on the falling edge; req is driven on the falling edge and held one cycle.
// Cycle numbering: the cycle in which a request is driven is cycle 0 of that scenario.
module tb_tune_player;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req = 3'b000;
    logic [13:0] note;
    logic        enable, busy, done;
    logic [1:0]  tune_id;

    int checks = 0;
    int passes = 0;
    int cyc;

    typedef struct {
        int          cyc;
        logic [2:0]  req;
        logic [13:0] note;
        logic        en;
        logic        busy;
        logic        done;
        logic [1:0]  tid;
    } vec_t;

    vec_t vecs[$];

    tune_player #(.TICK_CYCLES(4), .GAP_TICKS(2)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .note(note),
        .enable(enable), .busy(busy), .done(done), .tune_id(tune_id)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_out(string name, logic [13:0] e_note, logic e_en, logic e_busy,
                             logic e_done, logic [1:0] e_tid);
        checks++;
        if (note === e_note && enable === e_en && busy === e_busy && done === e_done && tune_id === e_tid)
            passes++;
        else
            $display("FAIL %s: got note=%0d en=%b busy=%b done=%b tid=%0d, want note=%0d en=%b busy=%b done=%b tid=%0d",
                     name, note, enable, busy, done, tune_id, e_note, e_en, e_busy, e_done, e_tid);
    endtask

    task automatic check_int(string name, int got, int want);
        checks++;
        if (got == want) passes++;
        else $display("FAIL %s: got %0d, want %0d", name, got, want);
    endtask

    // One busy segment of constant expected outputs; optionally injects a request at offset inj_at.
    task automatic run_seg(string name, int len, logic [13:0] e_note, logic e_en, logic [1:0] e_tid,
                           logic [2:0] inj_req, int inj_at);
        int    bad;
        string msg;
        bad = 0;
        msg = "";
        for (int j = 0; j < len; j++) begin
            if (!(note === e_note && enable === e_en && busy === 1'b1 && done === 1'b0 && tune_id === e_tid)) begin
                if (bad == 0)
                    msg = $sformatf("offset %0d note=%0d en=%b busy=%b done=%b tid=%0d",
                                    j, note, enable, busy, done, tune_id);
                bad++;
            end
            if (j == inj_at) req = inj_req;
            step();
            req = 3'b000;
        end
        checks++;
        if (bad == 0) passes++;
        else $display("FAIL %s: %0d bad cycles, first %s; want note=%0d en=%b busy=1 done=0 tid=%0d",
                      name, bad, msg, e_note, e_en, e_tid);
    endtask

    initial begin
        int f[4];
        int d[4];
        int n;
        int ndone;

        // Drop tune, then 3'b011 in the done cycle (invalid wins), then a dropped lower request.
        vecs.push_back('{0,    3'b001, 14'd0,   1'b0, 1'b0, 1'b0, 2'd3});
        vecs.push_back('{1,    3'b000, 14'd880, 1'b1, 1'b1, 1'b0, 2'd0});
        vecs.push_back('{160,  3'b000, 14'd880, 1'b1, 1'b1, 1'b0, 2'd0});
        vecs.push_back('{161,  3'b000, 14'd0,   1'b0, 1'b1, 1'b0, 2'd0});
        vecs.push_back('{168,  3'b000, 14'd0,   1'b0, 1'b1, 1'b0, 2'd0});
        vecs.push_back('{169,  3'b011, 14'd0,   1'b0, 1'b0, 1'b1, 2'd3});
        vecs.push_back('{170,  3'b000, 14'd220, 1'b1, 1'b1, 1'b0, 2'd1});
        vecs.push_back('{171,  3'b001, 14'd220, 1'b1, 1'b1, 1'b0, 2'd1});
        vecs.push_back('{172,  3'b000, 14'd220, 1'b1, 1'b1, 1'b0, 2'd1});
        vecs.push_back('{569,  3'b000, 14'd220, 1'b1, 1'b1, 1'b0, 2'd1});
        vecs.push_back('{570,  3'b000, 14'd0,   1'b0, 1'b1, 1'b0, 2'd1});
        vecs.push_back('{577,  3'b000, 14'd0,   1'b0, 1'b1, 1'b0, 2'd1});
        vecs.push_back('{578,  3'b000, 14'd165, 1'b1, 1'b1, 1'b0, 2'd1});
        vecs.push_back('{1177, 3'b000, 14'd165, 1'b1, 1'b1, 1'b0, 2'd1});
        vecs.push_back('{1178, 3'b000, 14'd0,   1'b0, 1'b1, 1'b0, 2'd1});
        vecs.push_back('{1185, 3'b000, 14'd0,   1'b0, 1'b1, 1'b0, 2'd1});
        vecs.push_back('{1186, 3'b000, 14'd0,   1'b0, 1'b0, 1'b1, 2'd3});
        vecs.push_back('{1187, 3'b000, 14'd0,   1'b0, 1'b0, 1'b0, 2'd3});

        // Reset state.
        repeat (2) @(negedge clk);
        check_out("reset_state", 14'd0, 1'b0, 1'b0, 1'b0, 2'd3);
        rst_n = 1'b1;
        step();

        // Table-driven timeline.
        cyc = 0;
        foreach (vecs[i]) begin
            while (cyc < vecs[i].cyc) begin
                step();
                req = 3'b000;
                cyc++;
            end
            check_out($sformatf("vec%0d_c%0d", i, vecs[i].cyc),
                      vecs[i].note, vecs[i].en, vecs[i].busy, vecs[i].done, vecs[i].tid);
            req = vecs[i].req;
        end

        // Win tune with a lower-priority drop request injected early in the first note.
        f = '{523, 659, 784, 1047};
        d = '{80, 80, 80, 240};
        req = 3'b100;
        step();
        req = 3'b000;
        for (int k = 0; k < 4; k++) begin
            run_seg($sformatf("win_note%0d", k), d[k] * 4, 14'(f[k]), 1'b1, 2'd2, 3'b001, (k == 0) ? 10 : -1);
            run_seg($sformatf("win_gap%0d", k), 8, 14'd0, 1'b0, 2'd2, 3'b000, -1);
        end
        check_out("win_done", 14'd0, 1'b0, 1'b0, 1'b1, 2'd3);
        step();
        check_out("win_after_done", 14'd0, 1'b0, 1'b0, 1'b0, 2'd3);

        // Preemption attempt: drop at cycle 0, win request at cycle 50.
        req = 3'b001;
        step();
        req = 3'b000;
        repeat (49) step();
        req = 3'b100;
        step();
        req = 3'b000;
        ndone = 0;
        n = 0;
`ifdef TUNE_PREEMPT_EN
        check_out("preempt_c51", 14'd523, 1'b1, 1'b1, 1'b0, 2'd2);
        while (busy && n < 5000) begin
            if (done) ndone++;
            step();
            n++;
        end
        check_int("preempt_win_len", n, 1952);
`else
        check_out("nopreempt_c51", 14'd880, 1'b1, 1'b1, 1'b0, 2'd0);
        while (busy && n < 5000) begin
            if (done) ndone++;
            step();
            n++;
        end
        check_int("nopreempt_done_cycle", 51 + n, 169);
`endif
        check_int("preempt_no_early_done", ndone, 0);
        check_out("preempt_final_done", 14'd0, 1'b0, 1'b0, 1'b1, 2'd3);
        step();

        // Asynchronous reset in the middle of a note, then a clean replay.
        req = 3'b010;
        step();
        req = 3'b000;
        repeat (20) step();
        #1;
        rst_n = 1'b0;
        #1;
        check_out("reset_async", 14'd0, 1'b0, 1'b0, 1'b0, 2'd3);
        step();
        step();
        check_out("reset_hold", 14'd0, 1'b0, 1'b0, 1'b0, 2'd3);
        rst_n = 1'b1;
        step();
        check_out("reset_release_idle", 14'd0, 1'b0, 1'b0, 1'b0, 2'd3);
        req = 3'b001;
        step();
        req = 3'b000;
        check_out("replay_c1", 14'd880, 1'b1, 1'b1, 1'b0, 2'd0);
        repeat (159) step();
        check_out("replay_c160", 14'd880, 1'b1, 1'b1, 1'b0, 2'd0);
        step();
        check_out("replay_c161_gap", 14'd0, 1'b0, 1'b1, 1'b0, 2'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
